// File: rtl/accel_host_sequencer_if.sv
// AXI4 bus between the accelerator host sequencer and the hostCtrl port.
// The master drives addresses, write data and the response readies. The slave drives the other readies and the B/R beats.
interface accel_host_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;

    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/accel_host_sequencer.sv
// Runs one accelerator job over AXI4. It writes the argument registers, then the start register,
// then polls the status register until the done bit is set, a bus error occurs or the poll budget runs out.
module accel_host_sequencer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    ID_WIDTH    = 8,
    parameter int                    NUM_ARGS    = 4,
    parameter logic [ADDR_WIDTH-1:0] ARG_BASE    = 'h0010,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 'h0000,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 'h0004,
    parameter int                    DONE_BIT    = 0,
    parameter int                    POLL_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [NUM_ARGS*DATA_WIDTH-1:0] cmd_args,
    input  logic [POLL_WIDTH-1:0]          cmd_max_polls,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [1:0]                     rsp_status,
    output logic [POLL_WIDTH-1:0]          rsp_polls,
    accel_host_sequencer_if.master         axi
);
    localparam int         BYTES = DATA_WIDTH / 8;
    localparam int         IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
    localparam logic [2:0] SIZE  = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

    localparam logic [1:0] ST_DONE    = 2'd0;
    localparam logic [1:0] ST_BUS_ERR = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        IDLE, ARG_AW, ARG_B, START_AW, START_B, POLL_AR, POLL_R, RESP
    } state_t;

    state_t                          state_reg, state_next;
    logic [NUM_ARGS*DATA_WIDTH-1:0]  args_reg, args_next;
    logic [POLL_WIDTH-1:0]           max_polls_reg, max_polls_next;
    logic [POLL_WIDTH-1:0]           polls_reg, polls_next;
    logic [IDX_W-1:0]                idx_reg, idx_next;
    logic                            aw_pend_reg, aw_pend_next;
    logic                            w_pend_reg, w_pend_next;
    logic [1:0]                      status_reg, status_next;

    logic [DATA_WIDTH-1:0]           arg_word [NUM_ARGS];
    logic                            aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                            unused_inputs;

    for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg_word
        assign arg_word[gi] = args_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // The pending flags are the AW/W valids, so each one drops on its own handshake.
    assign axi.awvalid = aw_pend_reg;
    assign axi.wvalid  = w_pend_reg;
    assign axi.bready  = (state_reg == ARG_B) || (state_reg == START_B);
    assign axi.arvalid = (state_reg == POLL_AR);
    assign axi.rready  = (state_reg == POLL_R);

    assign axi.awaddr  = (state_reg == START_AW) ? START_ADDR
                       : ARG_BASE + ADDR_WIDTH'(idx_reg) * ADDR_WIDTH'(BYTES);
    assign axi.wdata   = (state_reg == START_AW) ? DATA_WIDTH'(1) : arg_word[idx_reg];
    assign axi.araddr  = STATUS_ADDR;

    assign axi.awid    = ID_WIDTH'(0);
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = SIZE;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.wstrb   = '1;
    assign axi.wlast   = 1'b1;
    assign axi.arid    = ID_WIDTH'(0);
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = SIZE;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;

    assign cmd_ready   = (state_reg == IDLE);
    assign rsp_valid   = (state_reg == RESP);
    assign rsp_status  = status_reg;
    assign rsp_polls   = polls_reg;

    assign aw_hs = aw_pend_reg && axi.awready;
    assign w_hs  = w_pend_reg && axi.wready;
    assign b_hs  = axi.bready && axi.bvalid;
    assign ar_hs = axi.arvalid && axi.arready;
    assign r_hs  = axi.rready && axi.rvalid;

    assign unused_inputs = ^{axi.bid, axi.rid, axi.rlast, axi.rdata};

    always_comb begin
        state_next     = state_reg;
        args_next      = args_reg;
        max_polls_next = max_polls_reg;
        polls_next     = polls_reg;
        idx_next       = idx_reg;
        aw_pend_next   = aw_pend_reg;
        w_pend_next    = w_pend_reg;
        status_next    = status_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    args_next      = cmd_args;
                    max_polls_next = cmd_max_polls;
                    idx_next       = '0;
                    polls_next     = '0;
                    aw_pend_next   = 1'b1;
                    w_pend_next    = 1'b1;
                    state_next     = ARG_AW;
                end
            end
            ARG_AW, START_AW: begin
                if (aw_hs) aw_pend_next = 1'b0;
                if (w_hs)  w_pend_next  = 1'b0;
                if (!aw_pend_next && !w_pend_next)
                    state_next = (state_reg == ARG_AW) ? ARG_B : START_B;
            end
            ARG_B: begin
                if (b_hs) begin
                    if (axi.bresp != 2'b00) begin
                        status_next = ST_BUS_ERR;
                        state_next  = RESP;
                    end else begin
                        aw_pend_next = 1'b1;
                        w_pend_next  = 1'b1;
                        if (idx_reg == IDX_W'(NUM_ARGS - 1)) begin
                            state_next = START_AW;
                        end else begin
                            idx_next   = idx_reg + IDX_W'(1);
                            state_next = ARG_AW;
                        end
                    end
                end
            end
            START_B: begin
                if (b_hs) begin
                    if (axi.bresp != 2'b00) begin
                        status_next = ST_BUS_ERR;
                        state_next  = RESP;
                    end else begin
                        state_next = POLL_AR;
                    end
                end
            end
            POLL_AR: begin
                if (ar_hs) begin
                    // Saturate so an unlimited budget can never wrap the count.
                    polls_next = (polls_reg == '1) ? polls_reg : polls_reg + POLL_WIDTH'(1);
                    state_next = POLL_R;
                end
            end
            POLL_R: begin
                if (r_hs) begin
                    if (axi.rresp != 2'b00) begin
                        status_next = ST_BUS_ERR;
                        state_next  = RESP;
                    end else if (axi.rdata[DONE_BIT]) begin
                        status_next = ST_DONE;
                        state_next  = RESP;
                    end else if ((max_polls_reg != '0) && (polls_reg == max_polls_reg)) begin
                        status_next = ST_TIMEOUT;
                        state_next  = RESP;
                    end else begin
                        state_next = POLL_AR;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            args_reg      <= '0;
            max_polls_reg <= '0;
            polls_reg     <= '0;
            idx_reg       <= '0;
            aw_pend_reg   <= 1'b0;
            w_pend_reg    <= 1'b0;
            status_reg    <= 2'd0;
        end else begin
            state_reg     <= state_next;
            args_reg      <= args_next;
            max_polls_reg <= max_polls_next;
            polls_reg     <= polls_next;
            idx_reg       <= idx_next;
            aw_pend_reg   <= aw_pend_next;
            w_pend_reg    <= w_pend_next;
            status_reg    <= status_next;
        end
    end
endmodule

// File: tb/tb_accel_host_sequencer.sv
// Bench for accel_host_sequencer: a reactive AXI slave, a job-level reference model and one monitor that
// checks every bus handshake and each response. It runs directed jobs first and then random ones.
module tb_accel_host_sequencer;
    localparam int DW = 32, AW = 16, IW = 8, NA = 4, PW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [NA*DW-1:0]  cmd_args = '0;
    logic [PW-1:0]     cmd_max_polls = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_status;
    logic [PW-1:0]     rsp_polls;

    always #5 clk = ~clk;

    accel_host_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    accel_host_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_args(cmd_args), .cmd_max_polls(cmd_max_polls),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_polls(rsp_polls),
        .axi(bus)
    );

    int total = 0, bad = 0;

    // Job knobs shared by the model and the slave
    int bad_write = -1, done_at = 1, bad_read = -1, aw_lag = 0, w_lag = 0;

    // Reference model results for the current job
    logic [AW-1:0] exp_awaddr[$];
    logic [DW-1:0] exp_wdata[$];
    int            exp_reads;
    logic [1:0]    exp_status;
    logic [PW-1:0] exp_polls;

    int ar_seen = 0, rsp_count = 0;
    bit busy = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Job outcome computed from the register-level rules, write by write and poll by poll.
    task automatic build_model(input logic [NA*DW-1:0] args, input logic [PW-1:0] maxp);
        exp_awaddr.delete();
        exp_wdata.delete();
        exp_reads  = 0;
        exp_status = 2'd0;
        exp_polls  = '0;
        for (int w = 0; w <= NA; w++) begin
            exp_awaddr.push_back((w < NA) ? AW'(16'h10 + 4 * w) : AW'(0));
            exp_wdata.push_back((w < NA) ? args[w*DW +: DW] : DW'(1));
            if (w == bad_write) begin
                exp_status = 2'd1;
                return;
            end
        end
        for (int p = 1; p <= 1000; p++) begin
            exp_reads = p;
            exp_polls = PW'(p);
            if (p == bad_read) begin exp_status = 2'd1; return; end
            if (p == done_at)  begin exp_status = 2'd0; return; end
            if (maxp != 0 && p == int'(maxp)) begin exp_status = 2'd2; return; end
        end
    endtask

    // Slave: sample handshakes on the falling edge and drive a response just after the rising edge.
    initial begin : slave
        int aw_wait = 0, w_wait = 0, wr_cnt = 0, rd_cnt = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, b_hs, ar_hs, r_hs, cmd_hs;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0; bus.bresp = 2'b00;
        bus.arready = 1; bus.rvalid = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1;
        forever begin
            @(negedge clk);
            aw_hs  = bus.awvalid && bus.awready;
            w_hs   = bus.wvalid && bus.wready;
            b_hs   = bus.bvalid && bus.bready;
            ar_hs  = bus.arvalid && bus.arready;
            r_hs   = bus.rvalid && bus.rready;
            cmd_hs = cmd_valid && cmd_ready;
            if (bus.awvalid && !bus.awready) aw_wait++;
            if (bus.wvalid && !bus.wready) w_wait++;
            @(posedge clk);
            #1;
            if (!rst_n || cmd_hs) begin
                wr_cnt = 0; rd_cnt = 0; aw_done = 0; w_done = 0; aw_wait = 0; w_wait = 0;
                bus.bvalid = 0; bus.rvalid = 0;
                bus.awready = (aw_lag == 0); bus.wready = (w_lag == 0);
                continue;
            end
            if (aw_hs) begin aw_done = 1; aw_wait = 0; end
            if (w_hs)  begin w_done = 1;  w_wait = 0;  end
            bus.awready = (aw_wait >= aw_lag);
            bus.wready  = (w_wait >= w_lag);
            if (b_hs) bus.bvalid = 0;
            if (aw_done && w_done) begin
                aw_done = 0; w_done = 0;
                bus.bvalid = 1;
                bus.bresp  = (wr_cnt == bad_write) ? 2'b10 : 2'b00;
                bus.bid    = IW'($urandom);
                wr_cnt++;
            end
            if (r_hs) bus.rvalid = 0;
            if (ar_hs) begin
                rd_cnt++;
                bus.rvalid   = 1;
                bus.rresp    = (rd_cnt == bad_read) ? 2'b10 : 2'b00;
                bus.rdata    = $urandom;
                bus.rdata[0] = (rd_cnt == done_at);
            end
        end
    end

    // Monitor: every cycle, check the handshakes against the model and the hold rules.
    initial begin : monitor
        bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rspv = 0, p_rspr = 0;
        logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
        logic [DW-1:0] p_wdata = '0;
        logic [1:0]    p_st = '0;
        logic [PW-1:0] p_pl = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_awv = 0; p_wv = 0; p_arv = 0; p_rspv = 0; busy = 0; ar_seen = 0;
                continue;
            end
            check("cmd_ready", cmd_ready, !busy);
            if (p_awv && !p_awr) check("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {bus.wvalid, bus.wdata}, {1'b1, p_wdata});
            if (p_arv && !p_arr) check("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_araddr});
            if (p_rspv && !p_rspr) check("rsp_hold", {rsp_valid, rsp_status, rsp_polls}, {1'b1, p_st, p_pl});
            if (bus.awvalid && bus.awready) begin
                check("aw_fields", {bus.awid, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot},
                      {8'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
                check("aw_expected", exp_awaddr.size() > 0, 1);
                if (exp_awaddr.size() > 0) check("aw_addr", bus.awaddr, exp_awaddr.pop_front());
            end
            if (bus.wvalid && bus.wready) begin
                check("w_fields", {bus.wstrb, bus.wlast}, {4'hF, 1'b1});
                check("w_expected", exp_wdata.size() > 0, 1);
                if (exp_wdata.size() > 0) check("w_data", bus.wdata, exp_wdata.pop_front());
            end
            if (bus.arvalid && bus.arready) begin
                ar_seen++;
                check("ar_fields", {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
                      {8'd0, 16'h0004, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0});
                if (ar_seen > exp_reads) check("ar_extra", ar_seen, exp_reads);
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_status", rsp_status, exp_status);
                check("rsp_polls", rsp_polls, exp_polls);
                check("ar_count", ar_seen, exp_reads);
                check("writes_left", exp_awaddr.size() + exp_wdata.size(), 0);
                rsp_count++;
                busy = 0;
            end
            if (cmd_valid && cmd_ready) begin
                busy = 1;
                ar_seen = 0;
            end
            p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
            p_wv = bus.wvalid;   p_wr = bus.wready;   p_wdata = bus.wdata;
            p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
            p_rspv = rsp_valid;  p_rspr = rsp_ready;  p_st = rsp_status; p_pl = rsp_polls;
        end
    end

    task automatic start_cmd(input logic [NA*DW-1:0] args, input logic [PW-1:0] maxp);
        int n = 0;
        build_model(args, maxp);
        @(posedge clk); #1;
        cmd_args = args; cmd_max_polls = maxp; cmd_valid = 1;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
        if (n >= 50) check("cmd_accept_timeout", n, 0);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_job(input logic [NA*DW-1:0] args, input logic [PW-1:0] maxp, input int rlag,
                           input bit poke, output logic [1:0] st, output logic [PW-1:0] pl, output int cycles);
        int start_cnt, n;
        rsp_ready = (rlag == 0);
        start_cmd(args, maxp);
        start_cnt = rsp_count;
        cycles = 0;
        st = 2'd3;
        pl = '1;
        forever begin
            @(negedge clk);
            if (rsp_valid || cycles >= 3000) break;
            @(posedge clk);
            cycles++;
        end
        if (cycles >= 3000) check("rsp_timeout", cycles, 0);
        st = rsp_status;
        pl = rsp_polls;
        if (rlag > 0) begin
            @(posedge clk); #1;
            if (poke) cmd_valid = 1;
            repeat (rlag - 2) @(posedge clk);
            #1 cmd_valid = 0;
            @(posedge clk); #1;
            rsp_ready = 1;
        end
        n = 0;
        while (rsp_count == start_cnt && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("rsp_ready_timeout", n, 0);
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic set_knobs(input int bw, input int da, input int br, input int al, input int wl);
        bad_write = bw; done_at = da; bad_read = br; aw_lag = al; w_lag = wl;
    endtask

    logic [NA*DW-1:0] args1;
    logic [1:0]       st;
    logic [PW-1:0]    pl;
    int               cyc;

    initial begin : driver
        int n;
        args1 = {32'd4, 32'd3, 32'd2, 32'd1};
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_status, rsp_polls}, 0);
        check("rst_bus", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
        @(posedge clk); #3 rst_n = 1;

        // Pin the model against hand-worked values.
        set_knobs(-1, 1, -1, 0, 0);
        build_model(args1, 0);
        check("model_addr1", exp_awaddr[1], 16'h14);
        check("model_addr4", exp_awaddr[4], 16'h0);
        check("model_data3", exp_wdata[3], 32'd4);
        check("model_start", exp_wdata[4], 32'd1);
        check("model_reads", exp_reads, 1);

        // 1: ideal slave, done on first read, 12 cycles from accept to rsp_valid
        run_job(args1, 0, 0, 0, st, pl, cyc);
        check("t1_status", st, 2'd0); check("t1_polls", pl, 1); check("t1_cycles", cyc, 12);
        $display("job t1: status=%0d polls=%0d cycles=%0d", st, pl, cyc);

        // 2: done on fifth read, unlimited budget
        set_knobs(-1, 5, -1, 0, 0);
        run_job(args1, 0, 0, 0, st, pl, cyc);
        check("t2_status", st, 2'd0); check("t2_polls", pl, 5);
        $display("job t2: status=%0d polls=%0d", st, pl);

        // 3: never done, budget of three
        set_knobs(-1, 0, -1, 0, 0);
        run_job(args1, 3, 0, 0, st, pl, cyc);
        check("t3_status", st, 2'd2); check("t3_polls", pl, 3);
        $display("job t3: status=%0d polls=%0d", st, pl);

        // 4: write error on argument 1, then read error on poll 2
        set_knobs(1, 1, -1, 0, 0);
        run_job(args1, 0, 0, 0, st, pl, cyc);
        check("t4a_status", st, 2'd1); check("t4a_polls", pl, 0);
        $display("job t4a: status=%0d polls=%0d", st, pl);
        set_knobs(-1, 0, 2, 0, 0);
        run_job(args1, 0, 0, 0, st, pl, cyc);
        check("t4b_status", st, 2'd1); check("t4b_polls", pl, 2);
        $display("job t4b: status=%0d polls=%0d", st, pl);

        // 5: skewed AW/W readiness
        set_knobs(-1, 1, -1, 3, 0);
        run_job(args1, 0, 0, 0, st, pl, cyc);
        check("t5a_status", st, 2'd0); check("t5a_polls", pl, 1);
        $display("job t5a: status=%0d polls=%0d", st, pl);
        set_knobs(-1, 1, -1, 0, 3);
        run_job(args1, 0, 0, 0, st, pl, cyc);
        check("t5b_status", st, 2'd0); check("t5b_polls", pl, 1);
        $display("job t5b: status=%0d polls=%0d", st, pl);

        // 6: response held for 10 cycles while a new request is offered
        set_knobs(-1, 2, -1, 0, 0);
        run_job(args1, 0, 10, 1, st, pl, cyc);
        check("t6_status", st, 2'd0); check("t6_polls", pl, 2);
        $display("job t6 hold: status=%0d polls=%0d", st, pl);

        // 6: reset while waiting for a poll response
        set_knobs(-1, 100, -1, 0, 0);
        start_cmd(args1, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(ar_seen >= 2 && bus.rready) && n < 200);
        if (n >= 200) check("t6_reach_poll", n, 0);
        #2 rst_n = 0;
        #1;
        check("t6_rst_bus", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        exp_awaddr.delete(); exp_wdata.delete();
        @(negedge clk);
        check("t6_post_rst", {cmd_ready, rsp_status, rsp_polls}, {1'b1, 2'd0, 16'd0});
        $display("job t6 reset: cmd_ready=%0b", cmd_ready);

        // Random jobs
        for (int j = 0; j < 24; j++) begin
            logic [NA*DW-1:0] a;
            logic [PW-1:0]    m;
            int               rl;
            for (int k = 0; k < NA; k++) a[k*DW +: DW] = $urandom;
            m  = PW'($urandom_range(0, 5));
            rl = $urandom_range(0, 3);
            set_knobs(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NA)) : -1,
                      $urandom_range(0, 6),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : -1,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if (m == 0 && done_at == 0 && bad_read < 0) done_at = 3;
            run_job(a, m, rl, 0, st, pl, cyc);
            check("rnd_status", st, exp_status);
            $display("job rnd%0d: max=%0d status=%0d polls=%0d", j, m, st, pl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
